// File: rtl/tube_scheduler.sv
// tube_scheduler: game-flow controller for the scrolling tube playfield.
// Owns the idle/run/over state machine, the scroll tick, tube spawning with a
// pseudo-random gap pattern, and the score.
// Optional build macro: TUBE_SCHED_BCD_EN (score kept as two packed BCD digits).
module tube_scheduler #(
  parameter int unsigned TICK_NORMAL  = 25000000,
  parameter int unsigned TICK_FAST    = 12500000,
  parameter int unsigned TICK_INSANE  = 6250000,
  parameter int unsigned SPACE_NORMAL = 12,
  parameter int unsigned SPACE_FAST   = 8,
  parameter int unsigned SPACE_INSANE = 6,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        collide,
  input  logic        pass_i,
  input  logic        SW1,
  input  logic        SW2,
  output logic        shift_tick,
  output logic        spawn,
  output logic [15:0] pattern_o,
  output logic        running,
  output logic        game_over,
  output logic [7:0]  score_o
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SP_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
  typedef enum logic [1:0] {M_NORMAL, M_FAST, M_INSANE} mode_t;

  state_t            state;
  mode_t             mode;
  logic [CNT_W-1:0]  tick_cnt;
  logic [SP_W-1:0]   sp_cnt;
  logic [7:0]        lfsr;

  // Speed selection: SW1 has priority over SW2.
  function automatic mode_t sel_mode(input logic sw1, input logic sw2);
    if (sw1)      return M_FAST;
    else if (sw2) return M_INSANE;
    else          return M_NORMAL;
  endfunction

  // Scroll-tick period in clk cycles for a mode.
  function automatic logic [CNT_W-1:0] period_of(input mode_t m);
    case (m)
      M_FAST:   return CNT_W'(TICK_FAST);
      M_INSANE: return CNT_W'(TICK_INSANE);
      default:  return CNT_W'(TICK_NORMAL);
    endcase
  endfunction

  // Spawn spacing in scroll ticks for a mode.
  function automatic logic [SP_W-1:0] space_of(input mode_t m);
    case (m)
      M_FAST:   return SP_W'(SPACE_FAST);
      M_INSANE: return SP_W'(SPACE_INSANE);
      default:  return SP_W'(SPACE_NORMAL);
    endcase
  endfunction

  // Column pattern: four-row gap starting at row g, everything else lit.
  function automatic logic [15:0] gap_pattern(input logic [3:0] nib);
    logic [3:0] g;
    g = (nib > 4'd12) ? (nib - 4'd4) : nib;
    return ~(16'h000F << g);
  endfunction

  // 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Saturating score increment (binary or packed BCD).
  function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef TUBE_SCHED_BCD_EN
    if (s == 8'h99)          return s;
    else if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    else                     return {s[7:4], s[3:0] + 4'd1};
`else
    if (s == 8'hFF) return s;
    else            return s + 8'd1;
`endif
  endfunction

  // Game FSM, scroll tick, spawn spacing, pattern generation and score.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      mode       <= M_NORMAL;
      tick_cnt   <= '0;
      sp_cnt     <= '0;
      lfsr       <= LFSR_SEED;
      shift_tick <= 1'b0;
      spawn      <= 1'b0;
      pattern_o  <= '0;
      running    <= 1'b0;
      game_over  <= 1'b0;
      score_o    <= '0;
    end else begin
      shift_tick <= 1'b0;
      spawn      <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_RUN;
            running   <= 1'b1;
            game_over <= 1'b0;
            score_o   <= '0;
            tick_cnt  <= '0;
            sp_cnt    <= '0;
            mode      <= sel_mode(SW1, SW2);
          end
        end
        S_RUN: begin
          if (pass_i) score_o <= score_inc(score_o);
          if (collide) begin
            state     <= S_OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else if (tick_cnt == period_of(mode) - CNT_W'(1)) begin
            tick_cnt   <= '0;
            shift_tick <= 1'b1;
            if (sp_cnt == '0) begin
              spawn     <= 1'b1;
              pattern_o <= gap_pattern(lfsr[3:0]);
              lfsr      <= lfsr_next(lfsr);
            end
            // >= guards against a spacing shrink leaving the counter past the end
            if (sp_cnt >= space_of(mode) - SP_W'(1)) sp_cnt <= '0;
            else                                      sp_cnt <= sp_cnt + SP_W'(1);
            mode <= sel_mode(SW1, SW2);
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
